// File: rtl/imem_loadable.sv
// Loadable instruction memory: self-initialises to FILL_WORD after reset or clear,
// then serves 1-cycle registered fetches and accepts word loads from the program-load port.
module imem_loadable #(
  parameter int unsigned           DATA_W    = 32,
  parameter int unsigned           ADDR_W    = 5,
  parameter int unsigned           DEPTH     = 32,
  parameter logic [DATA_W-1:0]     FILL_WORD = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] instru,
  output logic              rd_err,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_err,
  output logic              ready
);

  localparam int unsigned     FC_W     = $clog2(DEPTH + 1);
  localparam int unsigned     IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [FC_W-1:0] LAST_IDX = FC_W'(DEPTH - 1);
  localparam logic [ADDR_W:0] DEPTH_A  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {
    S_INIT,
    S_READY
  } state_e;

  state_e            state_q, state_d;
  logic [FC_W-1:0]   fill_cnt_q, fill_cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] instru_q, instru_d;
  logic              rd_err_q, rd_err_d;
  logic              ld_err_q, ld_err_d;

  logic              is_ready;
  logic              rd_acc, ld_acc;
  logic              rd_oob, ld_oob;
  logic              ld_wr;
  logic [IDX_W-1:0]  rd_idx, ld_idx, fill_idx;

  always_comb begin
    is_ready = (state_q == S_READY);
    rd_oob   = ({1'b0, rd_addr} >= DEPTH_A);
    ld_oob   = ({1'b0, ld_addr} >= DEPTH_A);
    rd_acc   = is_ready && rd_req;
    ld_acc   = is_ready && ld_en;
    ld_wr    = ld_acc && !ld_oob;
    rd_idx   = rd_addr[IDX_W-1:0];
    ld_idx   = ld_addr[IDX_W-1:0];
    fill_idx = fill_cnt_q[IDX_W-1:0];
  end

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    unique case (state_q)
      S_INIT: begin
        fill_cnt_d = fill_cnt_q + FC_W'(1);
        if (fill_cnt_q == LAST_IDX) begin
          state_d = S_READY;
        end
      end
      S_READY: begin
        if (clear) begin
          state_d    = S_INIT;
          fill_cnt_d = '0;
        end
      end
      default: begin
        state_d    = S_INIT;
        fill_cnt_d = '0;
      end
    endcase
  end

  // Same-address load bypasses the array so the fetch sees the new word (write-first).
  always_comb begin
    rd_valid_d = rd_acc;
    instru_d   = instru_q;
    rd_err_d   = rd_err_q;
    ld_err_d   = ld_acc && ld_oob;
    if (rd_acc) begin
      if (rd_oob) begin
        instru_d = FILL_WORD;
        rd_err_d = 1'b1;
      end else begin
        rd_err_d = 1'b0;
        if (ld_wr && (ld_addr == rd_addr)) begin
          instru_d = ld_data;
        end else begin
          instru_d = mem_q[rd_idx];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_INIT;
      fill_cnt_q <= '0;
      rd_valid_q <= 1'b0;
      instru_q   <= '0;
      rd_err_q   <= 1'b0;
      ld_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      rd_valid_q <= rd_valid_d;
      instru_q   <= instru_d;
      rd_err_q   <= rd_err_d;
      ld_err_q   <= ld_err_d;
    end
  end

  // Array has no reset; INIT sweeps it. Loads can only occur in READY, so the ports never collide.
  always_ff @(posedge clk) begin
    if (state_q == S_INIT) begin
      mem_q[fill_idx] <= FILL_WORD;
    end else if (ld_wr) begin
      mem_q[ld_idx] <= ld_data;
    end
  end

  assign ready    = is_ready;
  assign rd_valid = rd_valid_q;
  assign instru   = instru_q;
  assign rd_err   = rd_err_q;
  assign ld_err   = ld_err_q;

endmodule
